// File: rtl/mo_line_buffer_scanout.sv
// Motion object line buffer read side: ping-pong banks, scan-out with
// clear-behind-read, horizontal flip and bank-swap overrun detection.
module mo_line_buffer_scanout #(
   parameter int PIX_W    = 8,
   parameter int ADDR_W   = 9,
   parameter int LINE_LEN = 336
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              pix_en,
   input  logic              line_start,
   input  logic              line_end,
   input  logic              flip,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [PIX_W-1:0]  wr_data,
   output logic [PIX_W-1:0]  mo_pix,
   output logic              mo_valid,
   output logic              busy,
   output logic              overrun
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LINE_LEN - 1);
   localparam logic [ADDR_W-1:0] MAX_A  = '1;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_SCAN
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
   logic              bank_sel_q, bank_sel_d;
   logic              flip_q, flip_d;
   logic [PIX_W-1:0]  mo_pix_q, mo_pix_d;
   logic              mo_valid_q, mo_valid_d;
   logic              overrun_q, overrun_d;
   logic              busy_q, busy_d;

   logic [PIX_W-1:0]  mem0 [DEPTH];
   logic [PIX_W-1:0]  mem1 [DEPTH];
   logic              we0, we1;
   logic [ADDR_W-1:0] wa0, wa1;
   logic [PIX_W-1:0]  wd0, wd1;
   logic [PIX_W-1:0]  rd_word;
   logic              rd_fire;
   logic              wr_fire;

   assign rd_word = bank_sel_q ? mem1[rd_addr_q] : mem0[rd_addr_q];
   assign wr_fire = wr_en && (wr_data[3:0] != 4'h0);

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      rd_addr_d  = rd_addr_q;
      pix_cnt_d  = pix_cnt_q;
      bank_sel_d = bank_sel_q;
      flip_d     = flip_q;
      mo_pix_d   = mo_pix_q;
      mo_valid_d = 1'b0;
      overrun_d  = overrun_q;
      rd_fire    = 1'b0;
      we0        = 1'b0;
      we1        = 1'b0;
      wa0        = '0;
      wa1        = '0;
      wd0        = '0;
      wd1        = '0;

      unique case (state_q)
         ST_INIT: begin
            we0        = 1'b1;
            we1        = 1'b1;
            wa0        = init_cnt_q;
            wa1        = init_cnt_q;
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == MAX_A) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (mo_valid_q) mo_pix_d = '0;
            if (line_end) bank_sel_d = ~bank_sel_q;
            if (line_start) begin
               state_d   = ST_SCAN;
               flip_d    = flip;
               rd_addr_d = flip ? LAST_A : '0;
               pix_cnt_d = '0;
            end
         end
         ST_SCAN: begin
            if (line_end) begin
               overrun_d  = 1'b1;
               bank_sel_d = ~bank_sel_q;
               state_d    = ST_IDLE;
            end else if (pix_en) begin
               rd_fire    = 1'b1;
               mo_pix_d   = rd_word;
               mo_valid_d = 1'b1;
               rd_addr_d  = flip_q ? rd_addr_q - 1'b1 : rd_addr_q + 1'b1;
               pix_cnt_d  = pix_cnt_q + 1'b1;
               if (pix_cnt_q == LAST_A) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_INIT;
      endcase

      // Display and fill banks never coincide, so the clear and the writer
      // each own one bank port in any cycle.
      if (state_q != ST_INIT) begin
         if (rd_fire) begin
            if (bank_sel_q) begin
               we1 = 1'b1;
               wa1 = rd_addr_q;
            end else begin
               we0 = 1'b1;
               wa0 = rd_addr_q;
            end
         end
         if (wr_fire) begin
            if (bank_sel_q) begin
               we0 = 1'b1;
               wa0 = wr_addr;
               wd0 = wr_data;
            end else begin
               we1 = 1'b1;
               wa1 = wr_addr;
               wd1 = wr_data;
            end
         end
      end

      busy_d = (state_d == ST_INIT);
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
         rd_addr_q  <= '0;
         pix_cnt_q  <= '0;
         bank_sel_q <= 1'b0;
         flip_q     <= 1'b0;
         mo_pix_q   <= '0;
         mo_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
         busy_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         rd_addr_q  <= rd_addr_d;
         pix_cnt_q  <= pix_cnt_d;
         bank_sel_q <= bank_sel_d;
         flip_q     <= flip_d;
         mo_pix_q   <= mo_pix_d;
         mo_valid_q <= mo_valid_d;
         overrun_q  <= overrun_d;
         busy_q     <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we0) mem0[wa0] <= wd0;
      if (we1) mem1[wa1] <= wd1;
   end

   assign mo_pix   = mo_pix_q;
   assign mo_valid = mo_valid_q;
   assign busy     = busy_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_mo_line_buffer_scanout.sv
// Directed bench for mo_line_buffer_scanout: vector table of single-pixel
// scans plus hand sequences for reset, flip, clear-behind-read and overrun.
module tb_mo_line_buffer_scanout;

   localparam int LL = 336;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       pix_en = 1'b0;
   logic       line_start = 1'b0;
   logic       line_end = 1'b0;
   logic       flip = 1'b0;
   logic       wr_en = 1'b0;
   logic [8:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic [7:0] mo_pix;
   logic       mo_valid;
   logic       busy;
   logic       overrun;

   int total = 0;
   int bad = 0;
   int nval;
   logic [7:0] got [LL];

   mo_line_buffer_scanout #(.PIX_W(8), .ADDR_W(9), .LINE_LEN(LL)) dut (
      .clk(clk), .clr(clr), .pix_en(pix_en),
      .line_start(line_start), .line_end(line_end), .flip(flip),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .mo_pix(mo_pix), .mo_valid(mo_valid), .busy(busy),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [8:0] addr;
      logic [7:0] data;
      logic       f;
      logic       swap;
      int         idx;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic capture();
      if (mo_valid) begin
         if (nval < LL) got[nval] = mo_pix;
         nval++;
      end
   endtask

   task automatic wr(input logic [8:0] a, input logic [7:0] d);
      wr_en = 1'b1;
      wr_addr = a;
      wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic swap_banks();
      line_end = 1'b1;
      tick();
      line_end = 1'b0;
   endtask

   task automatic scan(input logic f, input logic sw, input logic pe0,
                       input int npix);
      nval = 0;
      for (int i = 0; i < LL; i++) got[i] = 8'h00;
      line_start = 1'b1;
      line_end = sw;
      flip = f;
      pix_en = pe0;
      tick();
      capture();
      line_start = 1'b0;
      line_end = 1'b0;
      pix_en = 1'b0;
      for (int k = 0; k < npix; k++) begin
         pix_en = 1'b1;
         tick();
         capture();
         pix_en = 1'b0;
         tick();
         capture();
      end
      repeat (3) begin
         tick();
         capture();
      end
   endtask

   function automatic int nz_except(input int a, input int b);
      int n = 0;
      for (int i = 0; i < LL; i++)
         if (i != a && i != b && got[i] != 8'h00) n++;
      return n;
   endfunction

   initial begin
      int bcnt;

      vecs[0] = '{9'd10,  8'h35, 1'b0, 1'b0, 10,  8'h35};
      vecs[1] = '{9'd335, 8'h7F, 1'b1, 1'b0, 0,   8'h7F};
      vecs[2] = '{9'd10,  8'h35, 1'b1, 1'b1, 325, 8'h35};
      vecs[3] = '{9'd11,  8'h40, 1'b0, 1'b0, 11,  8'h00};
      vecs[4] = '{9'd0,   8'h9A, 1'b1, 1'b0, 335, 8'h9A};
      vecs[5] = '{9'd400, 8'hC1, 1'b0, 1'b1, 0,   8'h00};
      vecs[6] = '{9'd200, 8'h0B, 1'b0, 1'b0, 200, 8'h0B};

      // reset
      repeat (3) tick();
      chk("rst_busy", busy, 1);
      chk("rst_pix", mo_pix, 0);
      chk("rst_valid", mo_valid, 0);
      chk("rst_ovr", overrun, 0);
      clr = 1'b1;
      bcnt = 0;
      while (busy && bcnt < 2000) begin
         bcnt++;
         tick();
      end
      chk("busy_len", bcnt, 512);
      chk("post_init_ovr", overrun, 0);

      scan(1'b0, 1'b0, 1'b0, LL);
      chk("init_b0_n", nval, LL);
      chk("init_b0_zero", nz_except(-1, -1), 0);
      swap_banks();
      scan(1'b0, 1'b0, 1'b0, LL);
      chk("init_b1_n", nval, LL);
      chk("init_b1_zero", nz_except(-1, -1), 0);

      // single-pixel vector table
      foreach (vecs[v]) begin
         wr(vecs[v].addr, vecs[v].data);
         if (!vecs[v].swap) swap_banks();
         scan(vecs[v].f, vecs[v].swap, 1'b0, LL);
         chk($sformatf("v%0d_n", v), nval, LL);
         chk($sformatf("v%0d_pix", v), got[vecs[v].idx], vecs[v].exp);
         chk($sformatf("v%0d_rest", v), nz_except(vecs[v].idx, -1), 0);
         chk($sformatf("v%0d_idle0", v), mo_pix, 0);
      end

      // multi-write line, normal then flipped
      wr(9'd10, 8'h35);
      wr(9'd11, 8'h40);
      wr(9'd335, 8'h7F);
      swap_banks();
      scan(1'b0, 1'b0, 1'b0, LL);
      chk("s2_n", nval, LL);
      chk("s2_p10", got[10], 8'h35);
      chk("s2_p11", got[11], 8'h00);
      chk("s2_p335", got[335], 8'h7F);
      chk("s2_rest", nz_except(10, 335), 0);
      chk("s2_idle0", mo_pix, 0);

      wr(9'd10, 8'h35);
      wr(9'd11, 8'h40);
      wr(9'd335, 8'h7F);
      swap_banks();
      scan(1'b1, 1'b0, 1'b0, LL);
      chk("s3_first", got[0], 8'h7F);
      chk("s3_p325", got[325], 8'h35);
      chk("s3_rest", nz_except(0, 325), 0);

      // clear-behind-read in both banks
      for (int r = 0; r < 2; r++) begin
         swap_banks();
         scan(1'b0, 1'b0, 1'b0, LL);
         chk($sformatf("s4_n%0d", r), nval, LL);
         chk($sformatf("s4_zero%0d", r), nz_except(-1, -1), 0);
      end

      // overrun
      wr(9'd200, 8'h55);
      swap_banks();
      scan(1'b0, 1'b0, 1'b0, 100);
      chk("ovr_n100", nval, 100);
      chk("ovr_pre", overrun, 0);
      swap_banks();
      chk("ovr_set", overrun, 1);
      nval = 0;
      repeat (5) begin
         pix_en = 1'b1;
         tick();
         capture();
         pix_en = 1'b0;
         tick();
         capture();
      end
      chk("ovr_stopped", nval, 0);
      swap_banks();
      scan(1'b0, 1'b0, 1'b0, LL);
      chk("ovr_oldbank", got[200], 8'h55);
      chk("ovr_rest", nz_except(200, -1), 0);
      chk("ovr_sticky", overrun, 1);

      // write on the swap clock lands in the pre-toggle fill bank
      wr_en = 1'b1;
      wr_addr = 9'd5;
      wr_data = 8'h21;
      line_end = 1'b1;
      tick();
      wr_en = 1'b0;
      line_end = 1'b0;
      scan(1'b0, 1'b0, 1'b0, LL);
      chk("s6_p5", got[5], 8'h21);
      chk("s6_rest", nz_except(5, -1), 0);
      swap_banks();
      scan(1'b0, 1'b0, 1'b0, LL);
      chk("s6_other", nz_except(-1, -1), 0);

      // pix_en on the line_start clock does not read
      wr(9'd0, 8'h12);
      swap_banks();
      scan(1'b0, 1'b0, 1'b1, LL);
      chk("pe0_n", nval, LL);
      chk("pe0_p0", got[0], 8'h12);
      chk("pe0_rest", nz_except(0, -1), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
